// File: rtl/shotclock_defs_pkg.sv
// Shared definitions for the shot-clock timer: state encoding, BCD width,
// default presets and small BCD helpers.
package shotclock_defs;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    localparam logic [7:0] LONG_DEFAULT  = 8'h24;
    localparam logic [7:0] SHORT_DEFAULT = 8'h14;

    // True when the low n nibbles of v are all valid BCD digits.
    function automatic logic bcd_valid(input logic [15:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            if (v[i*BCD_W +: BCD_W] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Single-digit decrement with 0 wrapping to 9; the caller handles the borrow.
    function automatic logic [BCD_W-1:0] nib_dec(input logic [BCD_W-1:0] d);
        case (d)
            4'd1:    return 4'd0;
            4'd2:    return 4'd1;
            4'd3:    return 4'd2;
            4'd4:    return 4'd3;
            4'd5:    return 4'd4;
            4'd6:    return 4'd5;
            4'd7:    return 4'd6;
            4'd8:    return 4'd7;
            4'd9:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

endpackage

// File: rtl/bcd_dec_chain.sv
// Combinational multi-digit BCD ripple decrement with a count==1 flag.
module bcd_dec_chain
    import shotclock_defs::*;
#(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic [NUM_DIGITS*BCD_W-1:0] count,
    output logic [NUM_DIGITS*BCD_W-1:0] count_next,
    output logic                        is_one
);

    localparam int unsigned DW = NUM_DIGITS * BCD_W;

    logic borrow;

    always_comb begin
        borrow     = 1'b1;
        count_next = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                count_next[i*BCD_W +: BCD_W] = nib_dec(count[i*BCD_W +: BCD_W]);
                borrow = (count[i*BCD_W +: BCD_W] == 4'd0);
            end else begin
                count_next[i*BCD_W +: BCD_W] = count[i*BCD_W +: BCD_W];
            end
        end
    end

    assign is_one = (count == DW'(1));

endmodule

// File: rtl/shotclock_timer.sv
// Shot-clock countdown core: tick prescaler, run/stop/expired FSM, dual presets,
// leading-zero blanking, expiry pulse and timed buzzer.
module shotclock_timer
    import shotclock_defs::*;
#(
    parameter int unsigned                  NUM_DIGITS  = 2,
    parameter int unsigned                  TICK_DIV    = 100_000_000,
    parameter logic [BCD_W*NUM_DIGITS-1:0]  LONG_VALUE  = LONG_DEFAULT,
    parameter logic [BCD_W*NUM_DIGITS-1:0]  SHORT_VALUE = SHORT_DEFAULT,
    parameter int unsigned                  BUZZ_CYCLES = 50_000_000,
    parameter bit                           BLANK_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_long,
    input  logic                          load_short,
    input  logic                          start,
    input  logic                          pause,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]         blank,
    output logic                          running,
    output logic                          zero,
    output logic                          expire,
    output logic                          buzzer
);

    localparam int unsigned DW = BCD_W * NUM_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BUZZ_CYCLES > 2) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_CYCLES - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_digits
        $error("shotclock_timer: NUM_DIGITS must be 1..4");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("shotclock_timer: TICK_DIV must be >= 2");
    end
    if (BUZZ_CYCLES < 1) begin : g_bad_buzz
        $error("shotclock_timer: BUZZ_CYCLES must be >= 1");
    end
    if (!bcd_valid(16'(LONG_VALUE), NUM_DIGITS)) begin : g_bad_long
        $error("shotclock_timer: LONG_VALUE holds a non-BCD nibble");
    end
    if (!bcd_valid(16'(SHORT_VALUE), NUM_DIGITS)) begin : g_bad_short
        $error("shotclock_timer: SHORT_VALUE holds a non-BCD nibble");
    end

    state_e          state_q;
    logic [DW-1:0]   digits_q;
    logic [PW-1:0]   presc_q;
    logic [BW-1:0]   buzz_cnt_q;
    logic            running_q;
    logic            expire_q;
    logic            buzzer_q;

    logic [DW-1:0]   dec_next;
    logic            is_one;
    logic            tick;

    bcd_dec_chain #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_dec (
        .count      (digits_q),
        .count_next (dec_next),
        .is_one     (is_one)
    );

    assign tick = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STOPPED;
            digits_q   <= LONG_VALUE;
            presc_q    <= '0;
            buzz_cnt_q <= '0;
            running_q  <= 1'b0;
            expire_q   <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (buzzer_q) begin
                if (buzz_cnt_q == BUZZ_LAST) buzzer_q   <= 1'b0;
                else                         buzz_cnt_q <= buzz_cnt_q + 1'b1;
            end

            if (load_long || load_short) begin
                // Loads override any tick in the same cycle; RUNNING keeps running.
                digits_q   <= load_long ? LONG_VALUE : SHORT_VALUE;
                presc_q    <= '0;
                buzzer_q   <= 1'b0;
                buzz_cnt_q <= '0;
                if (state_q == ST_EXPIRED) begin
                    state_q   <= ST_STOPPED;
                    running_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_RUNNING: begin
                        if (tick) begin
                            presc_q  <= '0;
                            digits_q <= dec_next;
                            if (is_one) begin
                                state_q    <= ST_EXPIRED;
                                running_q  <= 1'b0;
                                expire_q   <= 1'b1;
                                buzzer_q   <= 1'b1;
                                buzz_cnt_q <= '0;
                            end else if (pause) begin
                                state_q   <= ST_STOPPED;
                                running_q <= 1'b0;
                            end
                        end else if (pause) begin
                            state_q   <= ST_STOPPED;
                            running_q <= 1'b0;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    ST_STOPPED: begin
                        // Prescaler is kept so a resume finishes the partial second.
                        if (start && !zero) begin
                            state_q   <= ST_RUNNING;
                            running_q <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                    end
                    default: begin
                        state_q   <= ST_STOPPED;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic upper_zero;

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        if (BLANK_EN) begin
            for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
                upper_zero = upper_zero && (digits_q[i*BCD_W +: BCD_W] == 4'd0);
                blank[i]   = upper_zero;
            end
        end
    end

    assign digits  = digits_q;
    assign zero    = (digits_q == '0);
    assign running = running_q;
    assign expire  = expire_q;
    assign buzzer  = buzzer_q;

endmodule

// File: doc/shotclock_timer.md
Name: shotclock_timer

Overview:
- Parametrised shot-clock countdown core. Replaces the fixed two-digit BCD counter and 1 Hz divider pair.
- Owns its tick prescaler, a run/stop/expired FSM, dual reload presets (long/short, e.g. 24/14), leading-zero blanking, an expiry pulse and a timed buzzer output.
- Drives sevenseg_mux digit inputs directly. Sits between the debounced button pulses and the display.

Parameters:
- NUM_DIGITS, 2, number of BCD digits counted and output (1..4).
- TICK_DIV, 100_000_000, clk cycles per count decrement (1 s at 100 MHz); must be ≥2.
- LONG_VALUE, 8'h24, BCD preset for load_long; width 4*NUM_DIGITS.
- SHORT_VALUE, 8'h14, BCD preset for load_short; width 4*NUM_DIGITS.
- BUZZ_CYCLES, 50_000_000, buzzer high time in clk cycles after expiry.
- BLANK_EN, 1, enable leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load_long  in  1  single-cycle pulse: reload LONG_VALUE.
- load_short  in  1  single-cycle pulse: reload SHORT_VALUE.
- start  in  1  single-cycle pulse: start/resume countdown.
- pause  in  1  single-cycle pulse: stop countdown, keep value.
- digits  out  4*NUM_DIGITS  packed BCD count; digit 0 in [3:0].
- blank  out  NUM_DIGITS  per-digit blank request (1 = display off).
- running  out  1  high in RUNNING state.
- zero  out  1  count == 0.
- expire  out  1  one-cycle pulse when count reaches 0.
- buzzer  out  1  high for BUZZ_CYCLES cycles after expire.

Behaviour:
- Reset values:
  - digits=LONG_VALUE, state=STOPPED, prescaler=0, running=0, zero=0, expire=0, buzzer=0.
  - blank is per the rule below.
- FSM states are STOPPED, RUNNING, EXPIRED.
- Input priority per cycle: rst > load_long > load_short > pause > start.
- Load (either pulse):
  - digits ← preset and prescaler ← 0 on the next edge.
  - buzzer cleared; buzz counter cleared.
  - RUNNING stays RUNNING (mid-play reset: first decrement TICK_DIV cycles later).
  - STOPPED stays STOPPED. EXPIRED → STOPPED.
- start:
  - STOPPED with count≠0 → RUNNING. Prescaler is not cleared; a resume continues the partial second.
  - Ignored in RUNNING, ignored in EXPIRED, ignored when count==0.
- pause: RUNNING → STOPPED; prescaler and digits frozen. Ignored elsewhere.
- Prescaler:
  - Increments only in RUNNING.
  - At TICK_DIV-1 it wraps to 0 and raises an internal tick for that cycle.
- Decrement on tick:
  - BCD ripple decrement. Digit 0 underflows 0→9 with a borrow into the next digit. No binary arithmetic on digits.
  - If count==1 before the tick: digits→0, expire=1 for exactly one cycle (registered, same edge as digits→0), state→EXPIRED, buzzer→1.
- EXPIRED:
  - Count held at 0; no wrap below 0 under any input.
  - buzzer stays high for BUZZ_CYCLES cycles, then 0. A load clears it early.
- A load and a tick in the same cycle: load wins, no decrement, no expire.
- A pause and a tick in the same cycle: the decrement happens (tick is already committed), then state → STOPPED.
- zero: combinational from digits (digits==0).
- running: registered state decode.
- blank:
  - When BLANK_EN=1, digit i>0 is blanked iff digit i and all higher digits are 0.
  - Digit 0 is never blanked.
  - When BLANK_EN=0, blank is all zeros.
- Presets holding an invalid BCD nibble (>9) are a parameter error; flag with an elaboration-time check.

Decomposition:
- Shared package/include shotclock_defs holds:
  - state encodings ST_STOPPED=2'd0, ST_RUNNING=2'd1, ST_EXPIRED=2'd2;
  - a BCD_W=4 constant;
  - the default preset constants (24/14).
- One sub-module, bcd_dec_chain (parameter NUM_DIGITS):
  - combinational BCD decrement;
  - outputs the next value and an is_one flag (count==1) used for expiry detection.
- The prescaler, buzz counter and FSM stay in shotclock_timer.

Test Plan:
- Use TICK_DIV=4 and BUZZ_CYCLES=6 for all scenarios.
- rst, then load_long, start → digits 24, 23, … at 4-cycle spacing. 10→09 shows blank=2'b10. Reaching 00 gives a single-cycle expire, running=0, zero=1, buzzer high exactly 6 cycles.
- Running at 17, pause 2 cycles into a second, wait 20 cycles, start → digits stay 17 while paused; 16 appears 2 cycles after resume.
- Running at 05, load_short → digits 14 next cycle, still running, 13 appears exactly 4 cycles later, no expire.
- load_long in the same cycle as a tick at 09 → digits 24, no 08 ever visible. In EXPIRED with buzzer high, load_long clears buzzer next cycle and state is STOPPED.
- At 00 in STOPPED, start → ignored (running stays 0). Assert rst mid-count at 11 → digits 24, STOPPED, buzzer=0 on the next edge.
- NUM_DIGITS=3, LONG_VALUE=12'h100, run → 100→099→098. blank=3'b100 at 099, blank=3'b110 at 009.
